// File: rtl/square_wave_gen.sv
// square_wave_gen: programmable square-wave / burst generator driving the downstream inverter stage
// Ports: clock/reset (sync, active-high); start/stop control; high_len/low_len/burst_cnt config
// (latched on accepted start); wave (registered waveform), busy, done (burst-complete pulse),
// periods (completed periods since last accepted start).
module square_wave_gen #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   high_len,
    input  logic [CNT_W-1:0]   low_len,
    input  logic [BURST_W-1:0] burst_cnt,
    output logic               wave,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] periods
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, hi_q, hi_d, lo_q, lo_d, h_last, l_last;
    logic [BURST_W-1:0] burst_q, burst_d, periods_q, periods_d, per_inc;
    logic               done_q, done_d;
    // a zero length is clamped to one cycle, so its last count index is 0
    assign h_last  = (hi_q == '0) ? '0 : hi_q - CNT_W'(1);
    assign l_last  = (lo_q == '0) ? '0 : lo_q - CNT_W'(1);
    assign per_inc = periods_q + BURST_W'(1);
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        burst_d   = burst_q;
        periods_d = periods_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: if (start && !stop) begin
                state_d   = HIGH;
                cnt_d     = '0;
                hi_d      = high_len;
                lo_d      = low_len;
                burst_d   = burst_cnt;
                periods_d = '0;
            end
            HIGH: begin
                state_d = stop ? IDLE : (cnt_q == h_last) ? LOW : HIGH;
                cnt_d   = (cnt_q == h_last) ? '0 : cnt_q + CNT_W'(1);
            end
            LOW: if (stop) begin
                state_d = IDLE;
            end else if (cnt_q == l_last) begin
                cnt_d     = '0;
                periods_d = per_inc;
                // burst_cnt of 0 means run forever
                done_d    = (burst_q != '0) && (per_inc == burst_q);
                state_d   = done_d ? IDLE : HIGH;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            burst_q   <= '0;
            periods_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            burst_q   <= burst_d;
            periods_q <= periods_d;
            done_q    <= done_d;
        end
    end
    assign wave    = (state_q == HIGH);
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign periods = periods_q;
endmodule

// File: tb/tb_square_wave_gen.sv
// tb_square_wave_gen: directed and random checks of square_wave_gen against a cycle-count model
module tb_square_wave_gen;
    logic       clock = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
    logic [7:0] high_len = '0, low_len = '0, burst_cnt = '0;
    logic       wave, busy, done;
    logic [7:0] periods;
    int         checks = 0, errors = 0;

    always #5 clock = ~clock;

    square_wave_gen #(.CNT_W(8), .BURST_W(8)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .high_len(high_len), .low_len(low_len), .burst_cnt(burst_cnt),
        .wave(wave), .busy(busy), .done(done), .periods(periods)
    );

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // model: k = cycles elapsed since the accepted start; period P = H+L
    bit en = 0, m_run = 0, m_done = 0;
    int m_k = 0, m_h = 0, m_l = 0, m_b = 0, m_per = 0;
    always @(posedge clock) begin
        if (reset) begin
            en = 1; m_run = 0; m_done = 0; m_k = 0; m_h = 0; m_l = 0; m_b = 0; m_per = 0;
        end else begin
            m_done = 0;
            if (!m_run) begin
                if (start && !stop) begin
                    m_run = 1; m_k = 0; m_per = 0;
                    m_h = (high_len == 0) ? 1 : int'(high_len);
                    m_l = (low_len == 0) ? 1 : int'(low_len);
                    m_b = int'(burst_cnt);
                end
            end else if (stop) begin
                m_run = 0;
            end else begin
                m_k++;
                m_per = (m_k / (m_h + m_l)) % 256;
                if (m_b != 0 && m_k / (m_h + m_l) == m_b) begin
                    m_run = 0; m_done = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (en) begin
            cmp("model_wave", int'(wave), m_run ? int'((m_k % (m_h + m_l)) < m_h) : 0);
            cmp("model_busy", int'(busy), int'(m_run));
            cmp("model_done", int'(done), int'(m_done));
            cmp("model_periods", int'(periods), m_per);
        end
    end

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [9:0]  pat10;
        logic [11:0] pat12;
        int dc, pf, prev;
        bit wrapped, sawdone;
        start = 1'b1; high_len = 8'd1; low_len = 8'd1; burst_cnt = 8'd1;
        for (int i = 0; i < 2; i++) begin
            tick();
            cmp("rst_wave", int'(wave), 0);
            cmp("rst_busy", int'(busy), 0);
            cmp("rst_done", int'(done), 0);
            cmp("rst_periods", int'(periods), 0);
        end
        reset = 1'b0;
        tick();
        start = 1'b0;
        cmp("post_rst_busy", int'(busy), 1);
        cmp("post_rst_wave", int'(wave), 1);
        tick(); tick(); tick();
        high_len = 8'd3; low_len = 8'd2; burst_cnt = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        pat10 = 10'b1110011100;
        for (int i = 0; i < 10; i++) begin
            cmp("burst_wave", int'(wave), int'(pat10[9-i]));
            cmp("burst_done_low", int'(done), 0);
            tick();
        end
        cmp("burst_done", int'(done), 1);
        cmp("burst_periods", int'(periods), 2);
        cmp("burst_busy_end", int'(busy), 0);
        tick();
        cmp("burst_done_once", int'(done), 0);
        high_len = 8'd0; low_len = 8'd0; burst_cnt = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        dc = 0;
        for (int i = 0; i < 8; i++) begin
            cmp("clamp_wave", int'(wave), int'(i % 2 == 0));
            dc += int'(done);
            tick();
        end
        cmp("clamp_done", int'(done), 1);
        cmp("clamp_done_early", dc, 0);
        cmp("clamp_periods", int'(periods), 4);
        tick();
        high_len = 8'd1; low_len = 8'd1; burst_cnt = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        wrapped = 0; sawdone = 0; prev = int'(periods);
        for (int i = 0; i < 600; i++) begin
            tick();
            if (prev == 255 && periods == 0) wrapped = 1;
            sawdone |= done;
            prev = int'(periods);
        end
        cmp("cont_wrap", int'(wrapped), 1);
        cmp("cont_no_done", int'(sawdone), 0);
        for (int i = 0; i < 4 && !wave; i++) tick();
        cmp("stop_in_high", int'(wave), 1);
        pf = int'(periods);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        cmp("stop_wave", int'(wave), 0);
        cmp("stop_busy", int'(busy), 0);
        cmp("stop_done", int'(done), 0);
        cmp("stop_periods", int'(periods), pf);
        tick();
        cmp("stop_periods_hold", int'(periods), pf);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        cmp("prio_busy", int'(busy), 0);
        cmp("prio_periods", int'(periods), pf);
        high_len = 8'd2; low_len = 8'd2; burst_cnt = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        pat12 = 12'b110011001100;
        for (int i = 0; i < 12; i++) begin
            cmp("ignore_wave", int'(wave), int'(pat12[11-i]));
            start = (i == 3);
            if (i == 3) high_len = 8'd7;
            tick();
        end
        start = 1'b0;
        cmp("ignore_done", int'(done), 1);
        cmp("ignore_periods", int'(periods), 3);
        tick();
        high_len = 8'd2; low_len = 8'd3; burst_cnt = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        cmp("mid_low_wave", int'(wave), 0);
        cmp("mid_low_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cmp("mid_rst_wave", int'(wave), 0);
        cmp("mid_rst_busy", int'(busy), 0);
        cmp("mid_rst_done", int'(done), 0);
        cmp("mid_rst_periods", int'(periods), 0);
        tick();
        cmp("mid_rst_no_done", int'(done), 0);
        for (int i = 0; i < 500; i++) begin
            reset     = ($urandom % 64) == 0;
            start     = ($urandom % 4) == 0;
            stop      = ($urandom % 16) == 0;
            high_len  = 8'($urandom % 6);
            low_len   = 8'($urandom % 6);
            burst_cnt = 8'($urandom % 5);
            tick();
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0;
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/square_wave_gen.md
Name: square_wave_gen

Overview:
- Programmable square-wave / burst generator. Produces the single-bit stimulus waveform that feeds the inverter stage directly downstream; its `wave` output connects to that stage's input.
- Replaces a free-running toggle with controlled high/low phase lengths, burst counts, start/stop control and completion status.
- Intended for bench and on-chip stimulus of the downstream gate stages.

Parameters:
- CNT_W, 8, width of phase-length inputs and the internal phase counter
- BURST_W, 8, width of the burst-count input and the `periods` counter

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request to begin generation; sampled each edge
- stop  input  1  request to abort generation; sampled each edge
- high_len  input  CNT_W  high-phase length in clock cycles; latched on accepted start
- low_len  input  CNT_W  low-phase length in clock cycles; latched on accepted start
- burst_cnt  input  BURST_W  number of full periods to generate; 0 = continuous; latched on accepted start
- wave  output  1  generated waveform, registered; feeds the inverter stage input
- busy  output  1  high while in HIGH or LOW state
- done  output  1  one-cycle pulse when a burst completes normally
- periods  output  BURST_W  completed full periods since the last accepted start

Behaviour:
- One clock; reset is synchronous and active-high; clock port `clock`, reset port `reset`.
- Reset: state=IDLE, wave=0, busy=0, done=0, periods=0, latched config=0. Reset has priority over all other inputs, including mid-operation.
- FSM states: IDLE, HIGH, LOW. wave=1 exactly in cycles where state==HIGH; busy=1 in HIGH or LOW; both are registered, with no combinational path from inputs.
- IDLE:
  - start=1 and stop=0 at edge t → latch high_len/low_len/burst_cnt, clear periods, enter HIGH.
  - wave=1 and busy=1 from cycle t+1 (latency 1).
- Zero-length clamp: a latched length of 0 is treated as 1. Every phase lasts at least one cycle.
- HIGH: lasts exactly H = max(high_len,1) cycles, then LOW.
- LOW: lasts exactly L = max(low_len,1) cycles. At the end of LOW, periods increments (wraps modulo 2^BURST_W).
  - Burst mode (latched burst_cnt ≠ 0): if the incremented value equals burst_cnt, go to IDLE and pulse done=1 in the first IDLE cycle. Otherwise go to HIGH.
  - Continuous mode (latched burst_cnt = 0): always go to HIGH; done is never asserted.
- Period: exactly H+L cycles, with wave high for the first H.
- Config inputs are ignored while busy; changes take effect only at the next accepted start.
- start while busy: ignored. No restart, no counter change.
- stop=1 at any edge while busy: next state IDLE, wave=0, busy=0, done stays 0, periods holds its value.
- start and stop both high in the same cycle: stop wins; from IDLE, nothing happens.
- done and start in the same IDLE cycle: the start is accepted normally; done still pulses for that one cycle.
- periods holds after a burst ends or is stopped, until the next accepted start or reset.

Test Plan:
- Reset sanity: reset=1 for 2 cycles with start=1 → wave=0, busy=0, done=0, periods=0 throughout; after release the first start pulse is accepted.
- Basic burst: high_len=3, low_len=2, burst_cnt=2, start pulsed at edge t → wave=1 for t+1..t+3, 0 for t+4..t+5, 1 for t+6..t+8, 0 for t+9..t+10. done=1 only at t+11; periods=2; busy=0 at t+11.
- Zero-length clamp: high_len=0, low_len=0, burst_cnt=4 → wave alternates 1,0 for 8 cycles; done pulses once; periods=4.
- Continuous + stop: burst_cnt=0, high_len=1, low_len=1, run 600 cycles → periods wraps 255→0, done never asserted. Assert stop mid-HIGH → next cycle wave=0, busy=0, done=0, periods frozen.
- Start/stop priority and ignore-while-busy: start=stop=1 in IDLE → stays IDLE. During a burst, pulse start with new high_len=7 → waveform unchanged, old config still in use.
- Reset mid-operation: assert reset during LOW of a burst → next cycle all outputs at reset values, no done pulse.
